// File: rtl/cpu_control_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_control_sequencer_if
// Description : Bundle of signals between the control sequencer and the
//               datapath / control-unit top level.
//               Inputs to the sequencer : IR, CON, Halt
//               Outputs from sequencer  : bus-drive strobes, register load
//                                         strobes, register-field selects,
//                                         memory strobes, ALUop, Run,
//                                         Illegal, State
//               master : the environment (drives IR/CON/Halt)
//               slave  : the sequencer (drives all control outputs)
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_control_sequencer_if;
    // Inputs to the sequencer
    logic [31:0] IR;
    logic        CON;
    logic        Halt;

    // Bus-drive strobes
    logic        PCout;
    logic        Zlowout;
    logic        MDRout;
    logic        Cout;
    logic        Rout;
    logic        BAout;

    // Register load / enable strobes
    logic        PCin;
    logic        IncPC;
    logic        MARin;
    logic        MDRin;
    logic        IRin;
    logic        Yin;
    logic        Zin;
    logic        Rin;
    logic        CONin;

    // Register-field selects
    logic        Gra;
    logic        Grb;
    logic        Grc;

    // Memory strobes
    logic        Read;
    logic        Write;

    // Status
    logic [3:0]  ALUop;
    logic        Run;
    logic        Illegal;
    logic [3:0]  State;

    modport master (
        output IR, CON, Halt,
        input  PCout, Zlowout, MDRout, Cout, Rout, BAout,
        input  PCin, IncPC, MARin, MDRin, IRin, Yin, Zin, Rin, CONin,
        input  Gra, Grb, Grc, Read, Write,
        input  ALUop, Run, Illegal, State
    );

    modport slave (
        input  IR, CON, Halt,
        output PCout, Zlowout, MDRout, Cout, Rout, BAout,
        output PCin, IncPC, MARin, MDRin, IRin, Yin, Zin, Rin, CONin,
        output Gra, Grb, Grc, Read, Write,
        output ALUop, Run, Illegal, State
    );
endinterface
`default_nettype wire

// File: rtl/cpu_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cpu_control_sequencer
// Description : Multi-cycle control sequencer for the bus-based CPU datapath.
//               Steps through fetch (T0-T2) and per-class execute states
//               (T3-T7), Moore-decoding every datapath strobe from the state
//               and the current opcode. Honours the external Halt request at
//               instruction boundaries and the halt opcode (sticky until clr).
// Ports       : clk  - system clock, rising edge
//               clr  - synchronous active-high reset
//               bus  - cpu_control_sequencer_if.slave (IR/CON/Halt in,
//                      all strobes, ALUop, Run, Illegal, State out)
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_control_sequencer (
    input  logic                           clk,
    input  logic                           clr,
    cpu_control_sequencer_if.slave         bus
);

    localparam logic [3:0] ST_RST    = 4'd0;
    localparam logic [3:0] ST_T0     = 4'd1;
    localparam logic [3:0] ST_T1     = 4'd2;
    localparam logic [3:0] ST_T2     = 4'd3;
    localparam logic [3:0] ST_T3     = 4'd4;
    localparam logic [3:0] ST_T4     = 4'd5;
    localparam logic [3:0] ST_T5     = 4'd6;
    localparam logic [3:0] ST_T6     = 4'd7;
    localparam logic [3:0] ST_T7     = 4'd8;
    localparam logic [3:0] ST_HALTED = 4'd9;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;

    logic [3:0] state;
    logic [3:0] state_next;
    logic [4:0] opcode_q;
    logic [4:0] opcode;
    logic       halt_op;
    logic       boundary;

    logic is_alu, is_addi, is_ldi, is_ld, is_st, is_br, is_nop, is_halt, is_illegal;

    // Only the opcode field steers sequencing; the register/constant fields
    // are consumed by the datapath.
    logic unused_ir;
    assign unused_ir = ^bus.IR[26:0];

    // In T3 the freshly loaded IR is decoded directly; from T4 onward the
    // opcode captured at the end of T3 is used, so IR may change freely
    // until the instruction boundary.
    assign opcode = (state == ST_T3) ? bus.IR[31:27] : opcode_q;

    assign is_alu  = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                     (opcode == OP_AND) || (opcode == OP_OR);
    assign is_addi = (opcode == OP_ADDI);
    assign is_ldi  = (opcode == OP_LDI);
    assign is_ld   = (opcode == OP_LD);
    assign is_st   = (opcode == OP_ST);
    assign is_br   = (opcode == OP_BR);
    assign is_nop  = (opcode == OP_NOP);
    assign is_halt = (opcode == OP_HALT);
    assign is_illegal = !(is_alu || is_addi || is_ldi || is_ld || is_st ||
                          is_br || is_nop || is_halt);

    // ------------------------------------------------------------------
    // Next-state logic. 'boundary' marks the last execute state of an
    // instruction; only there is the Halt request honoured.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        boundary   = 1'b0;
        case (state)
            ST_RST: state_next = ST_T0;
            ST_T0:  state_next = ST_T1;
            ST_T1:  state_next = ST_T2;
            ST_T2:  state_next = ST_T3;
            ST_T3: begin
                if (is_halt)
                    state_next = ST_HALTED;
                else if (is_nop || is_illegal)
                    boundary = 1'b1;
                else
                    state_next = ST_T4;
            end
            ST_T4:  state_next = ST_T5;
            ST_T5: begin
                if (is_ld || is_st || is_br)
                    state_next = ST_T6;
                else
                    boundary = 1'b1;
            end
            ST_T6: begin
                if (is_br)
                    boundary = 1'b1;
                else
                    state_next = ST_T7;
            end
            ST_T7:  boundary = 1'b1;
            ST_HALTED: begin
                if (!halt_op && !bus.Halt)
                    state_next = ST_T0;
            end
            default: state_next = ST_RST;
        endcase
        if (boundary)
            state_next = bus.Halt ? ST_HALTED : ST_T0;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= ST_RST;
            opcode_q <= 5'd0;
            halt_op  <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_T3) begin
                opcode_q <= bus.IR[31:27];
                if (is_halt)
                    halt_op <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Moore strobe decode
    // ------------------------------------------------------------------
    always_comb begin
        bus.PCout   = 1'b0;
        bus.Zlowout = 1'b0;
        bus.MDRout  = 1'b0;
        bus.Cout    = 1'b0;
        bus.Rout    = 1'b0;
        bus.BAout   = 1'b0;
        bus.PCin    = 1'b0;
        bus.IncPC   = 1'b0;
        bus.MARin   = 1'b0;
        bus.MDRin   = 1'b0;
        bus.IRin    = 1'b0;
        bus.Yin     = 1'b0;
        bus.Zin     = 1'b0;
        bus.Rin     = 1'b0;
        bus.CONin   = 1'b0;
        bus.Gra     = 1'b0;
        bus.Grb     = 1'b0;
        bus.Grc     = 1'b0;
        bus.Read    = 1'b0;
        bus.Write   = 1'b0;
        bus.ALUop   = ALU_ADD;
        bus.Illegal = 1'b0;
        case (state)
            ST_T0: begin
                bus.PCout = 1'b1;
                bus.MARin = 1'b1;
                bus.IncPC = 1'b1;
                bus.Zin   = 1'b1;
            end
            ST_T1: begin
                bus.Zlowout = 1'b1;
                bus.PCin    = 1'b1;
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
            end
            ST_T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            ST_T3: begin
                if (is_alu || is_addi || is_ldi || is_ld || is_st) begin
                    bus.Grb   = 1'b1;
                    bus.Yin   = 1'b1;
                    // ldi/ld/st use R0-as-zero addressing via BAout
                    bus.Rout  = is_alu || is_addi;
                    bus.BAout = is_ldi || is_ld || is_st;
                end else if (is_br) begin
                    bus.Gra   = 1'b1;
                    bus.Rout  = 1'b1;
                    bus.CONin = 1'b1;
                end
                bus.Illegal = is_illegal;
            end
            ST_T4: begin
                if (is_alu) begin
                    bus.Grc  = 1'b1;
                    bus.Rout = 1'b1;
                    bus.Zin  = 1'b1;
                    case (opcode)
                        OP_SUB:  bus.ALUop = ALU_SUB;
                        OP_AND:  bus.ALUop = ALU_AND;
                        OP_OR:   bus.ALUop = ALU_OR;
                        default: bus.ALUop = ALU_ADD;
                    endcase
                end else if (is_addi || is_ldi || is_ld || is_st) begin
                    bus.Cout = 1'b1;
                    bus.Zin  = 1'b1;
                end else if (is_br) begin
                    bus.PCout = 1'b1;
                    bus.Yin   = 1'b1;
                end
            end
            ST_T5: begin
                if (is_alu || is_addi || is_ldi) begin
                    bus.Zlowout = 1'b1;
                    bus.Gra     = 1'b1;
                    bus.Rin     = 1'b1;
                end else if (is_ld || is_st) begin
                    bus.Zlowout = 1'b1;
                    bus.MARin   = 1'b1;
                end else if (is_br) begin
                    bus.Cout = 1'b1;
                    bus.Zin  = 1'b1;
                end
            end
            ST_T6: begin
                if (is_ld) begin
                    bus.Read  = 1'b1;
                    bus.MDRin = 1'b1;
                end else if (is_st) begin
                    bus.Gra   = 1'b1;
                    bus.Rout  = 1'b1;
                    bus.MDRin = 1'b1;
                end else if (is_br) begin
                    bus.Zlowout = 1'b1;
                    bus.PCin    = bus.CON;
                end
            end
            ST_T7: begin
                if (is_ld) begin
                    bus.MDRout = 1'b1;
                    bus.Gra    = 1'b1;
                    bus.Rin    = 1'b1;
                end else if (is_st) begin
                    bus.Write = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.Run   = (state != ST_RST) && (state != ST_HALTED);
    assign bus.State = state;

endmodule
`default_nettype wire

// File: tb/tb_cpu_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_control_sequencer
// Description : Self-checking bench for cpu_control_sequencer. A table of
//               instruction records checks cycle counts and end states, a
//               few directed sequences cover clr/Halt/halt-opcode corners,
//               and a randomized run compares every cycle against per-class
//               strobe lists built from the instruction-level rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_control_sequencer;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    cpu_control_sequencer_if bif ();

    cpu_control_sequencer dut (
        .clk (clk),
        .clr (clr),
        .bus (bif)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Observation word: {22 strobes, ALUop[3:0], State[3:0]}
    localparam logic [21:0] M_PCOUT = 22'h200000;
    localparam logic [21:0] M_ZLOW  = 22'h100000;
    localparam logic [21:0] M_MDROUT= 22'h080000;
    localparam logic [21:0] M_COUT  = 22'h040000;
    localparam logic [21:0] M_ROUT  = 22'h020000;
    localparam logic [21:0] M_BAOUT = 22'h010000;
    localparam logic [21:0] M_PCIN  = 22'h008000;
    localparam logic [21:0] M_INCPC = 22'h004000;
    localparam logic [21:0] M_MARIN = 22'h002000;
    localparam logic [21:0] M_MDRIN = 22'h001000;
    localparam logic [21:0] M_IRIN  = 22'h000800;
    localparam logic [21:0] M_YIN   = 22'h000400;
    localparam logic [21:0] M_ZIN   = 22'h000200;
    localparam logic [21:0] M_RIN   = 22'h000100;
    localparam logic [21:0] M_CONIN = 22'h000080;
    localparam logic [21:0] M_GRA   = 22'h000040;
    localparam logic [21:0] M_GRB   = 22'h000020;
    localparam logic [21:0] M_GRC   = 22'h000010;
    localparam logic [21:0] M_READ  = 22'h000008;
    localparam logic [21:0] M_WRITE = 22'h000004;
    localparam logic [21:0] M_ILL   = 22'h000002;
    localparam logic [21:0] M_RUN   = 22'h000001;

    logic [29:0] exp_q[$];

    function automatic logic [29:0] observe();
        return {bif.PCout, bif.Zlowout, bif.MDRout, bif.Cout, bif.Rout, bif.BAout,
                bif.PCin, bif.IncPC, bif.MARin, bif.MDRin, bif.IRin, bif.Yin,
                bif.Zin, bif.Rin, bif.CONin, bif.Gra, bif.Grb, bif.Grc,
                bif.Read, bif.Write, bif.Illegal, bif.Run, bif.ALUop, bif.State};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input logic [29:0] exp, input string name);
        logic [29:0] act;
        act = observe();
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: outputs got %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_v(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected output for one cycle: Run follows from the state.
    function automatic logic [29:0] mk(input int st, input logic [21:0] m, input int alu);
        logic [21:0] mm;
        mm = m | ((st != 0 && st != 9) ? M_RUN : 22'h0);
        return {mm, 4'(alu), 4'(st)};
    endfunction

    // Per-cycle expectations for one instruction, fetch through last execute
    // state. State numbers: T0=1 ... T7=8.
    task automatic gen_instr(input logic [4:0] op, input logic con);
        exp_q.delete();
        exp_q.push_back(mk(1, M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 0));
        exp_q.push_back(mk(2, M_ZLOW | M_PCIN | M_READ | M_MDRIN, 0));
        exp_q.push_back(mk(3, M_MDROUT | M_IRIN, 0));
        case (op)
            5'd3, 5'd4, 5'd5, 5'd6: begin      // add/sub/and/or
                exp_q.push_back(mk(4, M_GRB | M_ROUT | M_YIN, 0));
                exp_q.push_back(mk(5, M_GRC | M_ROUT | M_ZIN, int'(op) - 3));
                exp_q.push_back(mk(6, M_ZLOW | M_GRA | M_RIN, 0));
            end
            5'd12, 5'd1: begin                 // addi / ldi
                exp_q.push_back(mk(4, M_GRB | M_YIN | ((op == 5'd12) ? M_ROUT : M_BAOUT), 0));
                exp_q.push_back(mk(5, M_COUT | M_ZIN, 0));
                exp_q.push_back(mk(6, M_ZLOW | M_GRA | M_RIN, 0));
            end
            5'd0, 5'd2: begin                  // ld / st
                exp_q.push_back(mk(4, M_GRB | M_BAOUT | M_YIN, 0));
                exp_q.push_back(mk(5, M_COUT | M_ZIN, 0));
                exp_q.push_back(mk(6, M_ZLOW | M_MARIN, 0));
                if (op == 5'd0) begin
                    exp_q.push_back(mk(7, M_READ | M_MDRIN, 0));
                    exp_q.push_back(mk(8, M_MDROUT | M_GRA | M_RIN, 0));
                end else begin
                    exp_q.push_back(mk(7, M_GRA | M_ROUT | M_MDRIN, 0));
                    exp_q.push_back(mk(8, M_WRITE, 0));
                end
            end
            5'd18: begin                       // br
                exp_q.push_back(mk(4, M_GRA | M_ROUT | M_CONIN, 0));
                exp_q.push_back(mk(5, M_PCOUT | M_YIN, 0));
                exp_q.push_back(mk(6, M_COUT | M_ZIN, 0));
                exp_q.push_back(mk(7, M_ZLOW | (con ? M_PCIN : 22'h0), 0));
            end
            5'd26, 5'd27: exp_q.push_back(mk(4, 22'h0, 0));   // nop / halt
            default:      exp_q.push_back(mk(4, M_ILL, 0));   // illegal
        endcase
    endtask

    typedef struct {
        logic [31:0] ir;
        logic        con;
        logic        halt;
        int          cycles;
        int          end_state;
        int          resume_state;
    } vec_t;

    vec_t vecs[15];
    logic [4:0] legal_ops[11];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] op;
        logic       con;
        logic       halt_b;
        logic       halted;
        int         cnt;

        vecs[0]  = '{32'h18918000, 1'b0, 1'b0, 6, 1, 1};   // add
        vecs[1]  = '{32'h20000000, 1'b0, 1'b0, 6, 1, 1};   // sub
        vecs[2]  = '{32'h28000000, 1'b0, 1'b0, 6, 1, 1};   // and
        vecs[3]  = '{32'h30000000, 1'b0, 1'b0, 6, 1, 1};   // or
        vecs[4]  = '{32'h60000000, 1'b0, 1'b0, 6, 1, 1};   // addi
        vecs[5]  = '{32'h08000000, 1'b0, 1'b0, 6, 1, 1};   // ldi
        vecs[6]  = '{32'h00800010, 1'b0, 1'b0, 8, 1, 1};   // ld
        vecs[7]  = '{32'h10000000, 1'b0, 1'b0, 8, 1, 1};   // st
        vecs[8]  = '{32'h92000005, 1'b1, 1'b0, 7, 1, 1};   // br taken
        vecs[9]  = '{32'h92000005, 1'b0, 1'b0, 7, 1, 1};   // br not taken
        vecs[10] = '{32'hD0000000, 1'b0, 1'b0, 4, 1, 1};   // nop
        vecs[11] = '{32'hF8000000, 1'b0, 1'b0, 4, 1, 1};   // illegal
        vecs[12] = '{32'h18918000, 1'b0, 1'b1, 6, 9, 1};   // add + Halt
        vecs[13] = '{32'h92000005, 1'b1, 1'b1, 7, 9, 1};   // br + Halt
        vecs[14] = '{32'hD8000000, 1'b0, 1'b0, 4, 9, 9};   // halt opcode

        legal_ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd12, 5'd18, 5'd26, 5'd27};

        // ---------------- reset ----------------
        clr = 1'b1; bif.IR = 32'h0; bif.CON = 1'b0; bif.Halt = 1'b0;
        tick(); tick();
        check(30'h0, "reset_state");
        clr = 1'b0;
        check(30'h0, "rst_after_release");
        tick();
        check(mk(1, M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 0), "first_t0");

        // ---------------- table-driven instruction lengths ----------------
        foreach (vecs[k]) begin
            bif.IR = vecs[k].ir; bif.CON = vecs[k].con; bif.Halt = vecs[k].halt;
            cnt = 0;
            do begin
                tick();
                cnt++;
            end while (bif.State != 4'd1 && bif.State != 4'd9 && cnt < 20);
            check_v($sformatf("len[%0d]", k), cnt, vecs[k].cycles);
            check_v($sformatf("end[%0d]", k), int'(bif.State), vecs[k].end_state);
            if (bif.State == 4'd9) begin
                bif.Halt = 1'b0;
                tick();
                check_v($sformatf("resume[%0d]", k), int'(bif.State), vecs[k].resume_state);
            end
            if (bif.State != 4'd1) begin
                clr = 1'b1; tick(); clr = 1'b0; tick();
            end
        end

        // ---------------- clr for two cycles mid-T4 of add ----------------
        bif.IR = 32'h18918000; bif.Halt = 1'b0;
        repeat (4) tick();
        check_v("clr_pre_t4", int'(bif.State), 5);
        clr = 1'b1; tick();
        check(30'h0, "clr_cycle1");
        tick();
        check(30'h0, "clr_cycle2");
        clr = 1'b0;
        check(30'h0, "clr_rst_hold");
        tick();
        check(mk(1, M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 0), "clr_then_t0");

        // ---------------- Halt raised during T4 of sub ----------------
        bif.IR = 32'h20000000;
        repeat (4) tick();
        check_v("sub_t4", int'(bif.State), 5);
        bif.Halt = 1'b1; tick();
        check(mk(6, M_ZLOW | M_GRA | M_RIN, 0), "sub_t5_completes");
        tick();
        check(mk(9, 22'h0, 0), "halt_req_halted");
        bif.Halt = 1'b0; tick();
        check_v("halt_drop_t0", int'(bif.State), 1);
        check_v("halt_drop_run", int'(bif.Run), 1);

        // ---------------- halt opcode is sticky ----------------
        bif.IR = 32'hD8000000;
        repeat (4) tick();
        check(mk(9, 22'h0, 0), "halt_op_halted");
        for (int i = 0; i < 4; i++) begin
            bif.Halt = i[0];
            tick();
            check(mk(9, 22'h0, 0), "halt_op_sticky");
        end
        bif.Halt = 1'b0;
        clr = 1'b1; tick();
        check(30'h0, "halt_op_clr");
        clr = 1'b0; tick();
        check_v("halt_op_clr_t0", int'(bif.State), 1);

        // ---------------- illegal pulse ----------------
        bif.IR = 32'hF8000000;
        repeat (3) tick();
        check(mk(4, M_ILL, 0), "illegal_t3");
        tick();
        check(mk(1, M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 0), "illegal_back_t0");

        // ---------------- randomized run against the model ----------------
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 2) == 0)
                op = 5'($urandom_range(0, 31));
            else
                op = legal_ops[$urandom_range(0, 10)];
            con    = 1'($urandom_range(0, 1));
            halt_b = ($urandom_range(0, 5) == 0);
            bif.IR  = {op, 27'($urandom)};
            bif.CON = con;
            gen_instr(op, con);
            for (int i = 0; i < exp_q.size(); i++) begin
                // Halt only matters at the last execute state; elsewhere it is noise.
                bif.Halt = (i == exp_q.size() - 1) ? halt_b : 1'($urandom_range(0, 1));
                #4;
                check(exp_q[i], $sformatf("rnd[%0d] op=%0d step=%0d", n, op, i));
                tick();
            end
            halted = halt_b || (op == 5'd27);
            if (halted) begin
                for (int j = 0; j < int'($urandom_range(1, 3)); j++) begin
                    bif.Halt = (op == 5'd27) ? 1'($urandom_range(0, 1)) : 1'b1;
                    #4;
                    check(mk(9, 22'h0, 0), "rnd_halted");
                    tick();
                end
                if (op == 5'd27) begin
                    clr = 1'b1;
                    bif.Halt = 1'($urandom_range(0, 1));
                    #4;
                    check(mk(9, 22'h0, 0), "rnd_halt_op_hold");
                    tick();
                    clr = 1'b0;
                    #4;
                    check(30'h0, "rnd_rst");
                    tick();
                end else begin
                    bif.Halt = 1'b0;
                    #4;
                    check(mk(9, 22'h0, 0), "rnd_halted_last");
                    tick();
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_control_sequencer.md
# cpu_control_sequencer

Multi-cycle control sequencer for the bus-based CPU datapath. It steps through fetch (T0–T2) and per-class execute states (T3–T7) and drives every register-enable, bus-drive, memory-strobe and ALU-op signal for the datapath. It also honours the external Halt run/stop request and the halt opcode. It sits inside the control-unit/bus top level, between the IR/CON flip-flop outputs and the datapath enables.

## Interface
- No parameters; opcode map fixed (see Operation).
- clk  in  1  system clock, all state changes on rising edge
- clr  in  1  synchronous, active-high reset
- IR  in  32  instruction register contents; opcode IR[31:27], ra [26:23], rb [22:19], rc [18:15], C [18:0]
- CON  in  1  branch-condition flip-flop output
- Halt  in  1  level run/stop request, sampled at instruction boundary
- PCout, Zlowout, MDRout, Cout, Rout, BAout  out  1 each  bus-drive strobes
- PCin, IncPC, MARin, MDRin, IRin, Yin, Zin, Rin, CONin  out  1 each  register load/enable strobes
- Gra, Grb, Grc  out  1 each  register-field selects
- Read, Write  out  1 each  memory strobes
- ALUop  out  4  0=ADD, 1=SUB, 2=AND, 3=OR; 0 whenever Zin=0
- Run  out  1  1 while sequencing instructions
- Illegal  out  1  one-cycle pulse on undefined opcode
- State  out  4  current state encoding, debug

## Operation
- States: RST=0, T0=1 … T7=8, HALTED=9. All strobes are Moore-decoded from State plus the registered IR opcode; unlisted strobes are 0.
- Fetch: T0 PCout, MARin, IncPC, Zin. T1 Zlowout, PCin, Read, MDRin. T2 MDRout, IRin.
- Opcodes:
  - ld=00000, ldi=00001, st=00010
  - add=00011, sub=00100, and=00101, or=00110
  - addi=01100, br=10010, nop=11010, halt=11011
  - any other opcode is illegal.
- add/sub/and/or: T3 Grb, Rout, Yin. T4 Grc, Rout, Zin, ALUop per opcode. T5 Zlowout, Gra, Rin. Then T0.
- addi/ldi: T3 Grb, (Rout for addi | BAout for ldi), Yin. T4 Cout, Zin, ADD. T5 Zlowout, Gra, Rin. Then T0.
- ld: T3 Grb, BAout, Yin. T4 Cout, Zin, ADD. T5 Zlowout, MARin. T6 Read, MDRin. T7 MDRout, Gra, Rin. Then T0.
- st: T3–T5 as ld. T6 Gra, Rout, MDRin. T7 Write. Then T0.
- br: T3 Gra, Rout, CONin. T4 PCout, Yin. T5 Cout, Zin, ADD. T6 Zlowout, PCin only if CON=1 (CON sampled in T6). Then T0.
- nop/illegal: T3 no strobes, then T0. Illegal=1 during that T3 only.
- halt opcode: T3 no strobes, then HALTED. Sets sticky flag halt_op.
- Instruction boundary is the last execute state of an instruction. At that edge, if Halt=1, go to HALTED instead of T0.
- HALTED: all strobes 0, Run=0.
  - halt_op=0: go to T0 on first edge with Halt=0.
  - halt_op=1: leave only via clr.
- Run=0 in RST and HALTED, 1 otherwise.

## Timing
- clr=1 at any edge: next state RST; halt_op cleared; all strobes 0, ALUop=0, Run=0, Illegal=0, State=0. Overrides Halt and any in-flight instruction; an aborted ld/st produces no further Read/Write.
- RST → T0 on first edge with clr=0. First T0 strobes appear one cycle after clr is deasserted.
- Cycle counts including fetch:
  - ALU / addi / ldi: 6
  - ld / st: 8
  - br: 7
  - nop / illegal: 4
  - halt: 4 to reach HALTED.
- IR is valid from T3 onward (loaded at the end of T2). The opcode is latched on entry to T3 and held to the boundary.
- Memory is synchronous: data is valid in the same cycle Read is asserted; MDRin captures it at that edge.
- Halt changes mid-instruction have no effect until the boundary. Halt=1 for one cycle at a non-boundary edge is ignored.
- Halt=1 and halt opcode in the same instruction: HALTED, halt_op=1.

## Test plan
- clr=1 for 2 cycles mid-T4 of add → State=0, all strobes 0, Run=0. After release: T0 with PCout=MARin=IncPC=Zin=1 exactly one cycle later.
- IR=0x18918000 (add R1,R2,R3) → T3 Grb/Rout/Yin, T4 Grc/Rout/Zin with ALUop=0, T5 Zlowout/Gra/Rin. Back at T0 on cycle 7.
- IR=0x00800010 (ld R1,0x10(R0)) → T3 BAout, T5 MARin, T6 Read+MDRin, T7 MDRout/Gra/Rin. 8-cycle period. Write never asserted.
- IR=0x92000005 (br R4) run twice: CON=1 → PCin=1 in T6; CON=0 → PCin=0 in T6. Both return to T0 after 7 cycles.
- Halt=1 raised during T4 of sub → instruction completes through T5, then HALTED, Run=0. Drop Halt → T0 next cycle, Run=1.
- IR=0xD8000000 (halt) → HALTED after T3. Toggling Halt does not leave HALTED; clr → RST → T0. IR=0xF8000000 → Illegal=1 for one T3 cycle, then T0.
